// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, with
// starvation-bounded priority for data, a per-access timeout, and registered memory/ack outputs.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              err_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stallreq_if_o,
    output logic              stallreq_d_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins contention until it has taken STARVE_MAX grants past a waiting fetch.
                if (d_req_i && (!if_req_i || starve_q < STARVE_LIM)) begin
                    state_d     = D_ACC;
                    starve_d    = if_req_i ? starve_q + SW'(1) : '0;
                    tmo_d       = '0;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_sel_d   = d_sel_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                end else if (if_req_i) begin
                    state_d     = IF_ACC;
                    starve_d    = '0;
                    tmo_d       = '0;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_sel_d   = 4'b1111;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                end
            end
            IF_ACC, D_ACC: begin
                if (mem_ack_i || tmo_q == TMO_LAST) begin
                    state_d  = RESP;
                    mem_ce_d = 1'b0;
                    err_d    = !mem_ack_i;
                    if (state_q == IF_ACC) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata_o    = if_rdata_q;
    assign if_ack_o      = if_ack_q;
    assign d_rdata_o     = d_rdata_q;
    assign d_ack_o       = d_ack_q;
    assign err_o         = err_q;
    assign mem_ce_o      = mem_ce_q;
    assign mem_we_o      = mem_we_q;
    assign mem_sel_o     = mem_sel_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign stallreq_if_o = if_req_i & ~if_ack_q;
    assign stallreq_d_o  = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [3:0]  d_sel_i = '0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        err_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stallreq_if_o;
    logic        stallreq_d_o;

    int vecs = 0;
    int errs = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .err_o(err_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_d_o(stallreq_d_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for mem_ce_o, records the address, then acks after lat ACC cycles.
    // Returns positioned in the RESP cycle with acks visible.
    task automatic serve(input int lat, input logic [31:0] rd, output bit ok, output logic [31:0] addr);
        ok = 1'b0;
        addr = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_ce_o) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            addr = mem_addr_o;
            repeat (lat - 1) tick();
            mem_ack_i = 1'b1;
            mem_rdata_i = rd;
            tick();
            mem_ack_i = 1'b0;
            mem_rdata_i = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if ({mem_ce_o, mem_we_o, if_ack_o, d_ack_o, err_o} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl got %b expected 00000", {mem_ce_o, mem_we_o, if_ack_o, d_ack_o, err_o});
        end
        vecs++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o, mem_sel_o} !== '0) begin
            errs++; $display("FAIL reset_data got addr %h wdata %h ird %h drd %h sel %h expected all 0",
                             mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o, mem_sel_o);
        end
    endtask

    task automatic test_fetch();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        tick();
        vecs++;
        if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            errs++; $display("FAIL fetch_req got ce %b we %b sel %h addr %h expected 1 0 f 00000100",
                             mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h3C011234;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        vecs++;
        if ({if_ack_o, d_ack_o, err_o, mem_ce_o, stallreq_if_o, if_rdata_o} !== {5'b10000, 32'h3C011234}) begin
            errs++; $display("FAIL fetch_ack got ack %b dack %b err %b ce %b stall %b rdata %h expected 1 0 0 0 0 3c011234",
                             if_ack_o, d_ack_o, err_o, mem_ce_o, stallreq_if_o, if_rdata_o);
        end
        if_req_i = 1'b0;
        tick();
        vecs++;
        if ({if_ack_o, if_rdata_o} !== {1'b0, 32'h3C011234}) begin
            errs++; $display("FAIL fetch_after got ack %b rdata %h expected 0 3c011234", if_ack_o, if_rdata_o);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [31:0] a;
        if_req_i = 1'b1; if_addr_i = 32'h104;
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h200;
        serve(1, 32'h11111111, ok, a);
        vecs++;
        if (!ok || a !== 32'h200) begin
            errs++; $display("FAIL simul_first got ok %b addr %h expected 1 00000200", ok, a);
        end
        vecs++;
        if ({d_ack_o, if_ack_o, stallreq_if_o, stallreq_d_o, d_rdata_o} !== {4'b1010, 32'h11111111}) begin
            errs++; $display("FAIL simul_dack got dack %b iack %b sif %b sd %b drd %h expected 1 0 1 0 11111111",
                             d_ack_o, if_ack_o, stallreq_if_o, stallreq_d_o, d_rdata_o);
        end
        d_req_i = 1'b0;
        tick();
        vecs++;
        if (stallreq_if_o !== 1'b1) begin
            errs++; $display("FAIL simul_stall_idle got %b expected 1", stallreq_if_o);
        end
        serve(1, 32'h22222222, ok, a);
        vecs++;
        if (!ok || a !== 32'h104) begin
            errs++; $display("FAIL simul_second got ok %b addr %h expected 1 00000104", ok, a);
        end
        vecs++;
        if ({if_ack_o, stallreq_if_o, if_rdata_o} !== {2'b10, 32'h22222222}) begin
            errs++; $display("FAIL simul_iack got ack %b stall %b rdata %h expected 1 0 22222222",
                             if_ack_o, stallreq_if_o, if_rdata_o);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        bit ok;
        logic [31:0] a;
        logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        if_req_i = 1'b1; if_addr_i = 32'h108;
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h300;
        for (int g = 0; g < 6; g++) begin
            serve(2, 32'h0, ok, a);
            vecs++;
            if (!ok || (a === 32'h300) !== exp_d[g]) begin
                errs++; $display("FAIL starve_grant%0d got ok %b addr %h expected data=%b", g, ok, a, exp_d[g]);
            end
            if (if_ack_o) if_req_i = 1'b0;
        end
        d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_store();
        bit seen = 1'b0;
        do_reset();
        d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011; d_addr_i = 32'h400; d_wdata_i = 32'hDEADBEEF;
        tick();
        d_wdata_i = 32'h0; d_sel_i = 4'hF; d_we_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vecs++;
            if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'b0011, 32'h400, 32'hDEADBEEF}) begin
                errs++; $display("FAIL store_hold%0d got ce %b we %b sel %b addr %h wdata %h expected 1 1 0011 00000400 deadbeef",
                                 c, mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o);
            end
            if (c < 2) tick();
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        seen = d_ack_o;
        vecs++;
        if ({seen, mem_ce_o, err_o} !== 3'b100) begin
            errs++; $display("FAIL store_ack got ack %b ce %b err %b expected 1 0 0", seen, mem_ce_o, err_o);
        end
        d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        logic [31:0] a;
        int n = 0;
        do_reset();
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h500;
        serve(1, 32'hA5A5A5A5, ok, a);
        vecs++;
        if (!ok || d_rdata_o !== 32'hA5A5A5A5) begin
            errs++; $display("FAIL tmo_preload got ok %b rdata %h expected 1 a5a5a5a5", ok, d_rdata_o);
        end
        tick();
        for (int i = 0; i < 3 && !mem_ce_o; i++) tick();
        while (mem_ce_o && n < 40) begin
            n++;
            tick();
        end
        vecs++;
        if (n !== 16) begin
            errs++; $display("FAIL tmo_cycles got %0d expected 16", n);
        end
        vecs++;
        if ({d_ack_o, err_o, d_rdata_o} !== {2'b11, 32'h0}) begin
            errs++; $display("FAIL tmo_abort got ack %b err %b rdata %h expected 1 1 00000000", d_ack_o, err_o, d_rdata_o);
        end
        d_req_i = 1'b0;
        tick();
        vecs++;
        if ({d_ack_o, err_o, mem_ce_o} !== 3'b000) begin
            errs++; $display("FAIL tmo_after got ack %b err %b ce %b expected 000", d_ack_o, err_o, mem_ce_o);
        end
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        logic [31:0] a;
        do_reset();
        d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF; d_addr_i = 32'h600; d_wdata_i = 32'h77;
        tick();
        vecs++;
        if (mem_ce_o !== 1'b1) begin
            errs++; $display("FAIL rstmid_grant got ce %b expected 1", mem_ce_o);
        end
        rst = 1'b1; d_req_i = 1'b0;
        tick();
        vecs++;
        if ({mem_ce_o, mem_we_o, d_ack_o, err_o, mem_addr_o} !== {4'b0, 32'h0}) begin
            errs++; $display("FAIL rstmid_clear got ce %b we %b ack %b err %b addr %h expected 0 0 0 0 0",
                             mem_ce_o, mem_we_o, d_ack_o, err_o, mem_addr_o);
        end
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        tick();
        vecs++;
        if ({d_ack_o, if_ack_o, err_o, d_rdata_o} !== {3'b0, 32'h0}) begin
            errs++; $display("FAIL rstmid_lateack got dack %b iack %b err %b rdata %h expected 0 0 0 0",
                             d_ack_o, if_ack_o, err_o, d_rdata_o);
        end
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h604;
        serve(1, 32'h12345678, ok, a);
        vecs++;
        if (!ok || a !== 32'h604 || {d_ack_o, err_o, d_rdata_o} !== {2'b10, 32'h12345678}) begin
            errs++; $display("FAIL rstmid_next got ok %b addr %h ack %b err %b rdata %h expected 1 00000604 1 0 12345678",
                             ok, a, d_ack_o, err_o, d_rdata_o);
        end
        d_req_i = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
